// File: rtl/apb_master.sv
// rtl/apb_master.sv - RV32I memory-phase to APB bridge with address decode.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master #(
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [NUM_SLV*32-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

  state_t      state;
  logic        dec_write;
  logic        mapped;
  logic        sel_ready;
  logic        timeout_hit;
  logic [31:0] sel_rdata;

  assign mapped    = (addr[31:16] == 16'h1000) && ({28'd0, addr[15:12]} < NUM_SLV);
  // PSEL is the registered one-hot index, so it doubles as the response mux select
  assign sel_ready = |(PREADY & PSEL);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[32*i +: 32];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign ready = (state == DECERR) || ((state == ACCESS) && (sel_ready || timeout_hit));
  assign err   = (state == DECERR) || ((state == ACCESS) && !sel_ready && timeout_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rdata     <= '0;
      dec_write <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            if (mapped) begin
              PADDR  <= addr;
              PWRITE <= write;
              PWDATA <= wdata;
              PSEL   <= NUM_SLV'(1) << addr[15:12];
              state  <= SETUP;
            end else begin
              dec_write <= write;
              state     <= DECERR;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: begin
`ifdef APB_TIMEOUT_EN
          cnt <= cnt + CW'(1);
`endif
          if (sel_ready) begin
            if (!PWRITE) rdata <= sel_rdata;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end else if (timeout_hit) begin
            if (!PWRITE) rdata <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end
        end
        DECERR: begin
          if (!dec_write) rdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master.
module tb_apb_master;

  logic         clk = 1'b0;
  logic         reset;
  logic         transfer;
  logic         write;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic         penable;
  logic [3:0]   psel;
  logic [127:0] prdata;
  logic [3:0]   pready;

  int checks = 0;
  int errors = 0;

  apb_master #(.NUM_SLV(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PENABLE(penable),
    .PSEL(psel), .PRDATA(prdata), .PREADY(pready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
  endtask

  // Bounded wait for ready, then drop transfer and check the read result.
  task automatic read_until_ready(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int n;
    req(1'b0, a, 32'h0);
    #1;
    n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    check({tag, "_ready_seen"}, {31'd0, ready}, 32'd1);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    step();
    transfer = 1'b0;
    #1;
    check({tag, "_rdata"}, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    pready = '0;
    prdata = {32'h3333_0003, 32'hCAFE_0001, 32'h1111_1111, 32'h0000_00AA};
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_psel", {28'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_pwrite", {31'd0, pwrite}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);

    // read slave 2, zero wait states
    pready = 4'b0100;
    req(1'b0, 32'h1000_2004, 32'h0);
    #1;
    check("rd2_c0_psel", {28'd0, psel}, 32'd0);
    step();
    check("rd2_c1_psel", {28'd0, psel}, 32'h4);
    check("rd2_c1_penable", {31'd0, penable}, 32'd0);
    check("rd2_c1_ready", {31'd0, ready}, 32'd0);
    step();
    check("rd2_c2_penable", {31'd0, penable}, 32'd1);
    check("rd2_c2_ready", {31'd0, ready}, 32'd1);
    check("rd2_c2_err", {31'd0, err}, 32'd0);
    step();
    transfer = 1'b0;
    #1;
    check("rd2_c3_rdata", rdata, 32'hCAFE_0001);
    check("rd2_c3_psel", {28'd0, psel}, 32'd0);
    check("rd2_c3_ready", {31'd0, ready}, 32'd0);

    // write slave 0 with 3 stall cycles; unselected slave 2 ready is ignored
    req(1'b1, 32'h1000_0010, 32'h1234_5678);
    step();
    check("wr_setup_psel", {28'd0, psel}, 32'h1);
    check("wr_setup_paddr", paddr, 32'h1000_0010);
    check("wr_setup_pwdata", pwdata, 32'h1234_5678);
    check("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      pready = (i == 3) ? 4'b0101 : 4'b0100;
      #1;
      check("wr_acc_penable", {31'd0, penable}, 32'd1);
      check("wr_acc_paddr", paddr, 32'h1000_0010);
      check("wr_acc_pwdata", pwdata, 32'h1234_5678);
      check("wr_acc_pwrite", {31'd0, pwrite}, 32'd1);
      check("wr_acc_ready", {31'd0, ready}, (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    transfer = 1'b0;
    #1;
    check("wr_rdata_kept", rdata, 32'hCAFE_0001);
    check("wr_paddr_held", paddr, 32'h1000_0010);
    check("wr_psel_off", {28'd0, psel}, 32'd0);

    // unmapped read
    req(1'b0, 32'h2000_0000, 32'h0);
    #1;
    check("um_c0_psel", {28'd0, psel}, 32'd0);
    step();
    check("um_c1_psel", {28'd0, psel}, 32'd0);
    check("um_c1_ready", {31'd0, ready}, 32'd1);
    check("um_c1_err", {31'd0, err}, 32'd1);
    step();
    transfer = 1'b0;
    #1;
    check("um_c2_rdata", rdata, 32'd0);
    check("um_c2_psel", {28'd0, psel}, 32'd0);
    check("um_c2_ready", {31'd0, ready}, 32'd0);

    // slave index beyond NUM_SLV is unmapped
    req(1'b1, 32'h1000_4000, 32'h5);
    step();
    check("um4_ready", {31'd0, ready}, 32'd1);
    check("um4_err", {31'd0, err}, 32'd1);
    check("um4_psel", {28'd0, psel}, 32'd0);
    step();
    transfer = 1'b0;

    // make rdata nonzero, then reset a stalled read in its first ACCESS cycle
    pready = 4'b0010;
    read_until_ready("pre_rst", 32'h1000_1000, 32'h1111_1111);
    pready = 4'b0000;
    req(1'b0, 32'h1000_3000, 32'h0);
    step();
    step();
    check("rst_mid_penable", {31'd0, penable}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    transfer = 1'b0;
    #1;
    check("rst_mid_psel", {28'd0, psel}, 32'd0);
    check("rst_mid_penable_low", {31'd0, penable}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    pready = 4'b1000;
    read_until_ready("post_rst", 32'h1000_3000, 32'h3333_0003);

    // back-to-back reads to slaves 1 then 3
    prdata[127:96] = 32'h3333_0033;
    pready = 4'b1010;
    req(1'b0, 32'h1000_1000, 32'h0);
    step();
    step();
    check("b2b_first_ready", {31'd0, ready}, 32'd1);
    step();
    req(1'b0, 32'h1000_3008, 32'h0);
    #1;
    check("b2b_idle_psel", {28'd0, psel}, 32'd0);
    check("b2b_first_rdata", rdata, 32'h1111_1111);
    step();
    check("b2b_setup_psel", {28'd0, psel}, 32'h8);
    check("b2b_setup_penable", {31'd0, penable}, 32'd0);
    step();
    check("b2b_acc_psel", {28'd0, psel}, 32'h8);
    check("b2b_second_ready", {31'd0, ready}, 32'd1);
    step();
    transfer = 1'b0;
    #1;
    check("b2b_second_rdata", rdata, 32'h3333_0033);

`ifdef APB_TIMEOUT_EN
    pready = 4'b0000;
    req(1'b0, 32'h1000_1000, 32'h0);
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      check("to_ready", {31'd0, ready}, (k == 16) ? 32'd1 : 32'd0);
      check("to_err", {31'd0, err}, (k == 16) ? 32'd1 : 32'd0);
    end
    step();
    transfer = 1'b0;
    #1;
    check("to_psel", {28'd0, psel}, 32'd0);
    check("to_penable", {31'd0, penable}, 32'd0);
    check("to_rdata", rdata, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
